// File: rtl/uart_byte_rx.sv
// UART byte receiver: 16x oversampling with 2-of-3 majority voting, optional parity,
// break handling and a small first-word-fall-through receive FIFO.
module uart_byte_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          rxd_in,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BREAK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [7:0] d, input int mode);
    if (mode == 1) return ~^d;
    else           return ^d;
  endfunction

  logic          sync1_q, rxd_s_q, prev_q;
  logic [1:0]    vld_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sc_q, sc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          s7_q, s7_d, s8_q, s8_d, maj_q, maj_d;
  logic          perr_flag_q, perr_flag_d;
  logic          frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic          push_s, pop_s, full_s, tick_s, fall_s;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;

  // Synchroniser; vld_q marks when rxd_s_q holds a genuine line sample so a line
  // already low at reset release cannot look like a falling edge.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      vld_q   <= 2'b00;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_in;
      rxd_s_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      prev_q  <= vld_q[1] & rxd_s_q;
    end
  end

  assign fall_s = vld_q[1] & prev_q & ~rxd_s_q;
  assign tick_s = (cnt_q == DIV_LAST);
  assign full_s = (level_q == FULL_LVL);
  assign pop_s  = (level_q != '0) && rx_ready;

  // Next-state logic for the receive FSM, sampling and error pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    sc_d         = sc_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    maj_d        = maj_q;
    perr_flag_d  = perr_flag_q;
    push_s       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    if (state_q == ST_IDLE || tick_s) cnt_d = '0;
    else                              cnt_d = cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: begin
        sc_d = 4'd0;
        if (fall_s) begin
          state_d     = ST_START;
          bit_d       = 3'd0;
          perr_flag_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_DATA, ST_PAR, ST_STOP: begin
        if (tick_s) begin
          sc_d = sc_q + 4'd1;
          case (sc_q)
            4'd7:  s7_d  = rxd_s_q;
            4'd8:  s8_d  = rxd_s_q;
            4'd9:  maj_d = maj3(s7_q, s8_q, rxd_s_q);
            4'd15: begin
              case (state_q)
                ST_START: begin
                  if (maj_q) state_d = ST_IDLE;
                  else       state_d = ST_DATA;
                end
                ST_DATA: begin
                  shift_d = {maj_q, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                  else               state_d = ST_DATA;
                end
                ST_PAR: begin
                  perr_flag_d = (maj_q != exp_parity(shift_q, PARITY));
                  state_d     = ST_STOP;
                end
                ST_STOP: begin
                  if (maj_q) begin
                    state_d = ST_IDLE;
                    if (perr_flag_q)           parity_err_d = 1'b1;
                    else if (full_s && !pop_s) overrun_d    = 1'b1;
                    else                       push_s       = 1'b1;
                  end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_BREAK;
                    sc_d        = 4'd0;
                  end
                end
                default: state_d = ST_IDLE;
              endcase
            end
            default: ;
          endcase
        end else begin
          sc_d = sc_q;
        end
      end
      ST_BREAK: begin
        // Any low sample restarts the one-bit-time high qualification.
        if (!rxd_s_q) begin
          sc_d  = 4'd0;
          cnt_d = '0;
        end else if (tick_s) begin
          if (sc_q == 4'd15) begin
            state_d = ST_IDLE;
            sc_d    = 4'd0;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end else begin
          sc_d = sc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Receive FSM, sampling registers and error pulse registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sc_q         <= 4'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      maj_q        <= 1'b1;
      perr_flag_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sc_q         <= sc_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      maj_q        <= maj_d;
      perr_flag_q  <= perr_flag_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Receive FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rx_valid   = (level_q != '0);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule
